// File: rtl/digital_cs_if.sv
// ============================================================================
//  Module      : digital_cs_if
//  Description : Control and CCD clock-phase bundle for the digital_cs sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface digital_cs_if;
   logic       enable;
   logic [1:0] f_select;
   logic       phi_p;
   logic       phi_l1;
   logic       phi_l2;
   logic       phi_r;

   modport master (
      output enable,
      output f_select,
      input  phi_p,
      input  phi_l1,
      input  phi_l2,
      input  phi_r
   );

   modport slave (
      input  enable,
      input  f_select,
      output phi_p,
      output phi_l1,
      output phi_l2,
      output phi_r
   );
endinterface

`default_nettype wire

// File: rtl/digital_cs.sv
// ============================================================================
//  Module      : digital_cs
//  Description : Linear-CCD clock sequencer (phi_p, phi_l1/phi_l2, phi_r) with
//                a 2^f_select tick prescaler. DIGITAL_CS_DEADTIME_EN selects a
//                6-tick pixel cycle with non-overlap dead ticks.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module digital_cs #(
   parameter int N_PIXELS = 16,
   parameter int P_TICKS  = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   digital_cs_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TRANSFER = 2'd1,
      ST_READ     = 2'd2
   } state_t;

   localparam logic [7:0]  c_p_last   = 8'(P_TICKS - 1);
   localparam logic [11:0] c_pix_last = 12'(N_PIXELS - 1);
`ifdef DIGITAL_CS_DEADTIME_EN
   localparam logic [2:0]  c_phase_last = 3'd5;
`else
   localparam logic [2:0]  c_phase_last = 3'd3;
`endif

   state_t      r_state;
   logic [2:0]  r_presc;
   logic [7:0]  r_tick_cnt;
   logic [11:0] r_pix;
   logic [2:0]  r_phase;
   logic [1:0]  r_fs_lat;
   logic        r_phi_p;
   logic        r_phi_l1;
   logic        r_phi_l2;
   logic        r_phi_r;

   state_t      w_state_nxt;
   logic [2:0]  w_presc_nxt;
   logic [7:0]  w_tick_cnt_nxt;
   logic [11:0] w_pix_nxt;
   logic [2:0]  w_phase_nxt;
   logic [1:0]  w_fs_nxt;
   logic [2:0]  w_presc_max;
   logic        w_tick;
   logic        w_phi_p;
   logic        w_phi_l1;
   logic        w_phi_l2;
   logic        w_phi_r;

   always_comb begin
      case (r_fs_lat)
         2'd0:    w_presc_max = 3'd0;
         2'd1:    w_presc_max = 3'd1;
         2'd2:    w_presc_max = 3'd3;
         default: w_presc_max = 3'd7;
      endcase
   end

   assign w_tick = (r_presc == w_presc_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_presc    <= 3'd0;
         r_tick_cnt <= 8'd0;
         r_pix      <= 12'd0;
         r_phase    <= 3'd0;
         r_fs_lat   <= 2'd0;
         r_phi_p    <= 1'b0;
         r_phi_l1   <= 1'b0;
         r_phi_l2   <= 1'b0;
         r_phi_r    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_presc    <= w_presc_nxt;
         r_tick_cnt <= w_tick_cnt_nxt;
         r_pix      <= w_pix_nxt;
         r_phase    <= w_phase_nxt;
         r_fs_lat   <= w_fs_nxt;
         r_phi_p    <= w_phi_p;
         r_phi_l1   <= w_phi_l1;
         r_phi_l2   <= w_phi_l2;
         r_phi_r    <= w_phi_r;
      end
   end

   // Dropping enable in any state returns to a fully cleared IDLE.
   always_comb begin
      w_state_nxt    = r_state;
      w_presc_nxt    = r_presc;
      w_tick_cnt_nxt = r_tick_cnt;
      w_pix_nxt      = r_pix;
      w_phase_nxt    = r_phase;
      w_fs_nxt       = r_fs_lat;
      if (!bus.enable) begin
         w_state_nxt    = ST_IDLE;
         w_presc_nxt    = 3'd0;
         w_tick_cnt_nxt = 8'd0;
         w_pix_nxt      = 12'd0;
         w_phase_nxt    = 3'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt    = ST_TRANSFER;
               w_fs_nxt       = bus.f_select;
               w_presc_nxt    = 3'd0;
               w_tick_cnt_nxt = 8'd0;
               w_pix_nxt      = 12'd0;
               w_phase_nxt    = 3'd0;
            end
            ST_TRANSFER: begin
               w_presc_nxt = w_tick ? 3'd0 : r_presc + 3'd1;
               if (w_tick) begin
                  if (r_tick_cnt == c_p_last) begin
                     w_state_nxt    = ST_READ;
                     w_tick_cnt_nxt = 8'd0;
                     w_pix_nxt      = 12'd0;
                     w_phase_nxt    = 3'd0;
                  end else begin
                     w_tick_cnt_nxt = r_tick_cnt + 8'd1;
                  end
               end
            end
            ST_READ: begin
               w_presc_nxt = w_tick ? 3'd0 : r_presc + 3'd1;
               if (w_tick) begin
                  if (r_phase == c_phase_last) begin
                     w_phase_nxt = 3'd0;
                     if (r_pix == c_pix_last) begin
                        w_state_nxt    = ST_TRANSFER;
                        w_fs_nxt       = bus.f_select;
                        w_presc_nxt    = 3'd0;
                        w_tick_cnt_nxt = 8'd0;
                        w_pix_nxt      = 12'd0;
                     end else begin
                        w_pix_nxt = r_pix + 12'd1;
                     end
                  end else begin
                     w_phase_nxt = r_phase + 3'd1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Outputs decode the next state so they land on the same edge as the transition.
   always_comb begin
      w_phi_p  = 1'b0;
      w_phi_l1 = 1'b0;
      w_phi_l2 = 1'b0;
      w_phi_r  = 1'b0;
      case (w_state_nxt)
         ST_TRANSFER: w_phi_p = 1'b1;
         ST_READ: begin
`ifdef DIGITAL_CS_DEADTIME_EN
            case (w_phase_nxt)
               3'd0: begin
                  w_phi_r  = 1'b1;
                  w_phi_l1 = 1'b1;
               end
               3'd1:       w_phi_l1 = 1'b1;
               3'd3, 3'd4: w_phi_l2 = 1'b1;
               default: ;
            endcase
`else
            case (w_phase_nxt)
               3'd0: begin
                  w_phi_r  = 1'b1;
                  w_phi_l1 = 1'b1;
               end
               3'd1:       w_phi_l1 = 1'b1;
               3'd2, 3'd3: w_phi_l2 = 1'b1;
               default: ;
            endcase
`endif
         end
         default: ;
      endcase
   end

   assign bus.phi_p  = r_phi_p;
   assign bus.phi_l1 = r_phi_l1;
   assign bus.phi_l2 = r_phi_l2;
   assign bus.phi_r  = r_phi_r;

endmodule

`default_nettype wire

// File: tb/tb_digital_cs.sv
// ============================================================================
//  Module      : tb_digital_cs
//  Description : Directed self-checking bench for digital_cs (default params).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_digital_cs;

`ifdef DIGITAL_CS_DEADTIME_EN
   localparam int c_pix_ticks = 6;
   localparam int c_frame     = 100;
   localparam int c_gaps      = 32;
`else
   localparam int c_pix_ticks = 4;
   localparam int c_frame     = 68;
   localparam int c_gaps      = 0;
`endif

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_miscmp;

   // {phi_p, phi_l1, phi_l2, phi_r} sampled on each falling edge
   logic [3:0] trace [0:2047];

   digital_cs_if bus ();

   digital_cs dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_miscmp++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] outs();
      return {bus.phi_p, bus.phi_l1, bus.phi_l2, bus.phi_r};
   endfunction

   task automatic capture(input int n, input int chg_at, input logic [1:0] chg_fs);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         trace[i] = outs();
         if (i == chg_at) bus.f_select = chg_fs;
      end
   endtask

   // Expected outputs idx clocks after a frame start, from the phase table.
   function automatic logic [3:0] exp_at(input int idx, input int fs);
      int t;
      int ph;
      t = (idx % (c_frame << fs)) >> fs;
      if (t < 4) return 4'b1000;
      ph = (t - 4) % c_pix_ticks;
`ifdef DIGITAL_CS_DEADTIME_EN
      case (ph)
         0:       return 4'b0101;
         1:       return 4'b0100;
         3, 4:    return 4'b0010;
         default: return 4'b0000;
      endcase
`else
      case (ph)
         0:       return 4'b0101;
         1:       return 4'b0100;
         default: return 4'b0010;
      endcase
`endif
   endfunction

   function automatic int pat_miss(input int from, input int to, input int base, input int fs);
      int m = 0;
      for (int i = from; i < to; i++)
         if (trace[i] !== exp_at(i - base, fs)) m++;
      return m;
   endfunction

   function automatic int cnt_bit(input int from, input int to, input int b);
      int c = 0;
      for (int i = from; i < to; i++)
         if (trace[i][b]) c++;
      return c;
   endfunction

   function automatic int cnt_rise(input int from, input int to, input int b);
      int c = 0;
      for (int i = from + 1; i < to; i++)
         if (trace[i][b] && !trace[i-1][b]) c++;
      return c;
   endfunction

   function automatic int cnt_nonzero(input int from, input int to);
      int c = 0;
      for (int i = from; i < to; i++)
         if (trace[i] != 4'b0000) c++;
      return c;
   endfunction

   function automatic int run_len(input int from, input int b);
      int c = 0;
      for (int i = from; i < 2048; i++) begin
         if (!trace[i][b]) break;
         c++;
      end
      return c;
   endfunction

   task automatic go_idle();
      bus.enable = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int prev;
      int bad;
      int first_rise;
      int l1_no_r;

      n_vec        = 0;
      n_miscmp     = 0;
      rst_n        = 1'b0;
      bus.enable   = 1'b0;
      bus.f_select = 2'd0;

      // Power-up reset, then idle with enable low
      repeat (3) @(negedge clk);
      check("rst_outputs", int'(outs()), 0);
      rst_n = 1'b1;
      capture(20, -1, 2'd0);
      check("idle_after_rst", cnt_nonzero(0, 20), 0);

      // Basic frame at fs=0
      bus.enable = 1'b1;
      capture(140, -1, 2'd0);
      check("fs0_phi_p_width", run_len(0, 3), 4);
      check("fs0_frame_pattern", pat_miss(0, c_frame, 0, 0), 0);
      check("fs0_phi_r_count", cnt_bit(0, c_frame, 0), 16);
      check("fs0_phi_l1_count", cnt_bit(0, c_frame, 2), 32);
      check("fs0_next_phi_p", int'(trace[c_frame][3]), 1);
      check("fs0_prev_phi_p", int'(trace[c_frame-1][3]), 0);
      check("gap_cycles", c_frame - 4 - cnt_bit(4, c_frame, 2) - cnt_bit(4, c_frame, 1), c_gaps);

      // Divide-by-4, f_select dropped to 0 mid-frame
      go_idle();
      bus.f_select = 2'd2;
      bus.enable   = 1'b1;
      capture(4*c_frame + 20, 100, 2'd0);
      check("fs2_phi_p_width", run_len(0, 3), 16);
      check("fs2_phi_r_width", run_len(16, 0), 4);
      check("fs2_frame_pattern", pat_miss(0, 4*c_frame, 0, 2), 0);
      check("fs2_period", int'(trace[4*c_frame][3]), 1);
      check("fs2_relatch_pattern", pat_miss(4*c_frame, 4*c_frame + 20, 4*c_frame, 0), 0);

      // Abort and restart
      go_idle();
      bus.enable = 1'b1;
      capture(500, -1, 2'd0);
      check("abort_run1_pattern", pat_miss(0, 500, 0, 0), 0);
      bus.enable = 1'b0;
      capture(100, -1, 2'd0);
      check("abort_first_clk", int'(trace[0]), 0);
      check("abort_all_low", cnt_nonzero(0, 100), 0);
      bus.enable = 1'b1;
      capture(500, -1, 2'd0);
      check("restart_phi_p", int'(trace[0][3]), 1);
      check("restart_pattern", pat_miss(0, 500, 0, 0), 0);

      // Ten continuous frames
      go_idle();
      bus.enable = 1'b1;
      capture(10*c_frame + 1, -1, 2'd0);
      bad = 0;
      l1_no_r = 0;
      for (int i = 0; i < 10*c_frame; i++) begin
         if (trace[i][2] && trace[i][1]) bad++;
         if (trace[i][0] && !trace[i][2]) bad++;
         if (i > 0 && trace[i][2] && !trace[i-1][2] && !trace[i][0]) l1_no_r++;
      end
      check("cont_invariants", bad, 0);
      check("cont_l1_rise_has_r", l1_no_r, 0);
      check("cont_phi_p_rises", cnt_rise(0, 10*c_frame + 1, 3), 10);
      check("cont_phi_r_pulses", cnt_rise(0, 10*c_frame, 0), 160);
      prev = 0;
      bad = 0;
      first_rise = -1;
      for (int i = 1; i <= 10*c_frame; i++) begin
         if (trace[i][3] && !trace[i-1][3]) begin
            if (first_rise < 0) first_rise = i;
            if (cnt_rise(prev, i, 0) != 16) bad++;
            prev = i;
         end
      end
      check("cont_r_per_frame", bad, 0);
      check("cont_frame_period", first_rise, c_frame);

      // Asynchronous reset mid-READ
      go_idle();
      bus.enable = 1'b1;
      repeat (30) @(negedge clk);
      check("pre_rst_phi_l1", int'(bus.phi_l1), 1);
      #2 rst_n = 1'b0;
      #1 check("async_rst_outputs", int'(outs()), 0);
      bus.enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      capture(20, -1, 2'd0);
      check("post_rst_idle", cnt_nonzero(0, 20), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule

`default_nettype wire
